// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter (core MEM stage vs host port).
package dmem_arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [0:0] {
    ST_SHARED    = 1'b0,
    ST_HOST_LOCK = 1'b1
  } arb_state_e;

  typedef enum logic [0:0] {
    OWN_CORE = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter used for the host wait and burst counters.
// Clear has priority; clear together with inc loads 1 so a counter can restart on a counted beat.
module arb_sat_counter
  import dmem_arb_pkg::*;
#(
  parameter logic [CNT_W-1:0] LIMIT = 4'd4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= {{(CNT_W-1){1'b0}}, inc_i};
    end else if (inc_i && (r_cnt != LIMIT)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: core (default priority) vs host with starvation bound and lock bursts.
// Optional DMEM_ARB_STATS_EN adds 32-bit grant/conflict statistics counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 64,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [ADDR_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wdata_i,
  output logic              core_gnt_o,
  output logic              core_stall_o,
  output logic              core_rvalid_o,
  output logic [DATA_W-1:0] core_rdata_o,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic              host_lock_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_gnt_o,
  output logic              host_rvalid_o,
  output logic [DATA_W-1:0] host_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_we_o,
  output logic              mem_re_o,
  input  logic [DATA_W-1:0] mem_rdata_i
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_core_gnt_o,
  output logic [31:0]       stat_host_gnt_o,
  output logic [31:0]       stat_conflict_o
`endif
);

  arb_state_e       r_state;
  owner_e           r_rd_owner;
  logic             r_rd_pend;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_core_rdata;
  logic [DATA_W-1:0] r_host_rdata;
  logic [CNT_W-1:0] w_wait_cnt;
  logic [CNT_W-1:0] w_burst_cnt;
  logic             w_core_gnt;
  logic             w_host_gnt;
  logic             w_gnt;
  logic             w_we;
  logic             w_core_rvalid;
  logic             w_host_rvalid;

  arb_sat_counter #(.LIMIT(CNT_W'(MAX_WAIT))) u_wait_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (host_req_i & ~w_host_gnt),
    .clr_i (w_host_gnt),
    .cnt_o (w_wait_cnt)
  );

  // Burst counter holds the number of host beats already granted in the current locked burst.
  arb_sat_counter #(.LIMIT(CNT_W'(MAX_BURST))) u_burst_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_host_gnt),
    .clr_i (r_state == ST_SHARED),
    .cnt_o (w_burst_cnt)
  );

  always_comb begin
    w_core_gnt = 1'b0;
    w_host_gnt = 1'b0;
    if (rst_i) begin
      w_core_gnt = 1'b0;
    end else begin
      case (r_state)
        ST_SHARED: begin
          w_host_gnt = host_req_i & (~core_req_i | (w_wait_cnt == CNT_W'(MAX_WAIT)));
          w_core_gnt = core_req_i & ~w_host_gnt;
        end
        ST_HOST_LOCK: w_host_gnt = host_req_i;
        default:      w_host_gnt = 1'b0;
      endcase
    end
  end

  assign w_gnt         = w_core_gnt | w_host_gnt;
  assign w_we          = w_host_gnt ? host_we_i : core_we_i;
  assign w_core_rvalid = ~rst_i & r_rd_pend & (r_rd_owner == OWN_CORE);
  assign w_host_rvalid = ~rst_i & r_rd_pend & (r_rd_owner == OWN_HOST);

  // Memory command and read-return muxing; everything is forced low while reset is held.
  always_comb begin
    mem_we_o = w_gnt & w_we;
    mem_re_o = w_gnt & ~w_we;
    if (rst_i) begin
      mem_addr_o   = '0;
      mem_wdata_o  = '0;
      core_rdata_o = '0;
      host_rdata_o = '0;
    end else begin
      mem_addr_o   = w_host_gnt ? host_addr_i  : (w_core_gnt ? core_addr_i  : r_addr);
      mem_wdata_o  = w_host_gnt ? host_wdata_i : (w_core_gnt ? core_wdata_i : r_wdata);
      core_rdata_o = w_core_rvalid ? mem_rdata_i : r_core_rdata;
      host_rdata_o = w_host_rvalid ? mem_rdata_i : r_host_rdata;
    end
  end

  assign core_gnt_o    = w_core_gnt;
  assign host_gnt_o    = w_host_gnt;
  assign core_stall_o  = ~rst_i & core_req_i & ~w_core_gnt;
  assign core_rvalid_o = w_core_rvalid;
  assign host_rvalid_o = w_host_rvalid;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_SHARED;
      r_rd_pend    <= 1'b0;
      r_rd_owner   <= OWN_CORE;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_core_rdata <= '0;
      r_host_rdata <= '0;
    end else begin
      // The beat that brings the burst to MAX_BURST beats is the last locked one.
      case (r_state)
        ST_SHARED: begin
          if (w_host_gnt && host_lock_i && (MAX_BURST > 1)) r_state <= ST_HOST_LOCK;
          else                                              r_state <= ST_SHARED;
        end
        ST_HOST_LOCK: begin
          if (!host_req_i || !host_lock_i || (w_burst_cnt == CNT_W'(MAX_BURST - 1)))
            r_state <= ST_SHARED;
          else
            r_state <= ST_HOST_LOCK;
        end
        default: r_state <= ST_SHARED;
      endcase
      r_rd_pend <= w_gnt & ~w_we;
      if (w_gnt) begin
        r_rd_owner <= w_host_gnt ? OWN_HOST : OWN_CORE;
        r_addr     <= mem_addr_o;
        r_wdata    <= mem_wdata_o;
      end
      if (w_core_rvalid) r_core_rdata <= mem_rdata_i;
      if (w_host_rvalid) r_host_rdata <= mem_rdata_i;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] r_stat_core;
  logic [31:0] r_stat_host;
  logic [31:0] r_stat_conf;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stat_core <= 32'd0;
      r_stat_host <= 32'd0;
      r_stat_conf <= 32'd0;
    end else begin
      r_stat_core <= r_stat_core + {31'd0, w_core_gnt};
      r_stat_host <= r_stat_host + {31'd0, w_host_gnt};
      r_stat_conf <= r_stat_conf + {31'd0, core_req_i & host_req_i};
    end
  end

  assign stat_core_gnt_o = r_stat_core;
  assign stat_host_gnt_o = r_stat_host;
  assign stat_conflict_o = r_stat_conf;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with a behavioural arbitration/memory model.
// Honours DMEM_ARB_STATS_EN to also check the statistics counters.
module tb_dmem_arbiter;

  localparam int MAX_WAIT  = 4;
  localparam int MAX_BURST = 8;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        core_req_i = 1'b0, core_we_i = 1'b0;
  logic [7:0]  core_addr_i = 8'd0;
  logic [63:0] core_wdata_i = 64'd0;
  logic        host_req_i = 1'b0, host_we_i = 1'b0, host_lock_i = 1'b0;
  logic [7:0]  host_addr_i = 8'd0;
  logic [63:0] host_wdata_i = 64'd0;
  logic [63:0] mem_rdata_i = 64'd0;
  logic        core_gnt_o, core_stall_o, core_rvalid_o, host_gnt_o, host_rvalid_o;
  logic        mem_we_o, mem_re_o;
  logic [63:0] core_rdata_o, host_rdata_o, mem_wdata_o;
  logic [7:0]  mem_addr_o;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stat_core_gnt_o, stat_host_gnt_o, stat_conflict_o;
`endif

  dmem_arbiter #(.ADDR_W(8), .DATA_W(64), .MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .core_req_i(core_req_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
    .core_wdata_i(core_wdata_i), .core_gnt_o(core_gnt_o), .core_stall_o(core_stall_o),
    .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .host_req_i(host_req_i), .host_we_i(host_we_i), .host_lock_i(host_lock_i),
    .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i), .host_gnt_o(host_gnt_o),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o),
    .mem_re_o(mem_re_o), .mem_rdata_i(mem_rdata_i)
`ifdef DMEM_ARB_STATS_EN
    , .stat_core_gnt_o(stat_core_gnt_o), .stat_host_gnt_o(stat_host_gnt_o),
    .stat_conflict_o(stat_conflict_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Environment memory: one-cycle read latency, driven only by the DUT command
  logic [63:0] bmem [256];
  always @(posedge clk_i) begin
    if (mem_we_o) bmem[mem_addr_o] <= mem_wdata_o;
    if (mem_re_o) mem_rdata_i <= bmem[mem_addr_o];
  end

  typedef struct {
    logic [6:0]  ctl;
    logic [7:0]  addr;
    logic [63:0] wdata;
    logic [63:0] core_rd;
    logic [63:0] host_rd;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state, expressed as plain arbitration rules
  logic [63:0] ref_mem [256];
  bit          m_locked, m_pend, m_owner_host;
  int          m_wait, m_beats;
  logic [63:0] m_pend_data, m_hold_core, m_hold_host, m_wdata_hold;
  logic [7:0]  m_addr_hold;
  int          m_st_core, m_st_host, m_st_conf;
  bit          e_cg, e_hg, e_crv, e_hrv;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_locked = 0; m_pend = 0; m_owner_host = 0; m_wait = 0; m_beats = 0;
    m_pend_data = '0; m_hold_core = '0; m_hold_host = '0;
    m_addr_hold = '0; m_wdata_hold = '0;
    m_st_core = 0; m_st_host = 0; m_st_conf = 0;
  endtask

  // Apply the effects of the cycle that just ended (inputs are still those of that cycle)
  task automatic commit();
    logic [7:0] a;
    logic [63:0] d;
    bit w;
    if (rst_i) begin
      model_reset();
    end else begin
      if (e_crv) m_hold_core = m_pend_data;
      if (e_hrv) m_hold_host = m_pend_data;
      m_pend = 0;
      if (e_cg || e_hg) begin
        a = e_hg ? host_addr_i : core_addr_i;
        d = e_hg ? host_wdata_i : core_wdata_i;
        w = e_hg ? host_we_i : core_we_i;
        m_addr_hold = a; m_wdata_hold = d;
        if (w) ref_mem[a] = d;
        else begin m_pend = 1; m_owner_host = e_hg; m_pend_data = ref_mem[a]; end
      end
      if (e_hg) m_wait = 0;
      else if (host_req_i && m_wait < MAX_WAIT) m_wait++;
      if (!m_locked) begin
        if (e_hg && host_lock_i && MAX_BURST > 1) begin m_locked = 1; m_beats = 1; end
      end else if (!host_req_i) begin
        m_locked = 0;
      end else begin
        m_beats++;
        if (!host_lock_i || m_beats == MAX_BURST) m_locked = 0;
      end
      m_st_core += int'(e_cg); m_st_host += int'(e_hg);
      m_st_conf += int'(core_req_i && host_req_i);
    end
  endtask

  // Predict the DUT outputs for the cycle whose inputs were just driven
  task automatic eval();
    exp_t x;
    bit w;
    if (rst_i) begin
      e_cg = 0; e_hg = 0; e_crv = 0; e_hrv = 0;
      x.ctl = 7'd0; x.addr = 8'd0; x.wdata = 64'd0; x.core_rd = 64'd0; x.host_rd = 64'd0;
    end else begin
      if (m_locked) begin
        e_hg = host_req_i; e_cg = 0;
      end else begin
        e_hg = host_req_i && (!core_req_i || m_wait == MAX_WAIT);
        e_cg = core_req_i && !e_hg;
      end
      e_crv = m_pend && !m_owner_host;
      e_hrv = m_pend && m_owner_host;
      w = e_hg ? host_we_i : core_we_i;
      x.ctl = {e_cg, e_hg, core_req_i && !e_cg, (e_cg || e_hg) && w, (e_cg || e_hg) && !w,
               e_crv, e_hrv};
      x.addr  = e_hg ? host_addr_i  : (e_cg ? core_addr_i  : m_addr_hold);
      x.wdata = e_hg ? host_wdata_i : (e_cg ? core_wdata_i : m_wdata_hold);
      x.core_rd = e_crv ? m_pend_data : m_hold_core;
      x.host_rd = e_hrv ? m_pend_data : m_hold_host;
    end
    sb.push_back(x);
  endtask

  // New requests only once the previous one was granted (or none was pending)
  task automatic gen(input int ph);
    if (!core_req_i || e_cg) begin
      core_req_i   = (ph != 0) ? 1'b1 : ($urandom_range(0, 99) < 55);
      core_we_i    = 1'($urandom_range(0, 1));
      core_addr_i  = 8'($urandom_range(0, 15));
      core_wdata_i = {$urandom, $urandom};
    end
    if (!host_req_i || e_hg) begin
      host_req_i   = (ph != 0) ? 1'b1 : ($urandom_range(0, 99) < 45);
      host_lock_i  = (ph == 2) ? 1'b1 : ((ph == 1) ? 1'b0 : ($urandom_range(0, 99) < 50));
      host_we_i    = 1'($urandom_range(0, 1));
      host_addr_i  = 8'($urandom_range(0, 15));
      host_wdata_i = {$urandom, $urandom};
    end
  endtask

  task automatic step(input int ph, input bit force_rst);
    @(posedge clk_i); #1;
    commit();
    if (force_rst) begin
      rst_i = 1'b1; core_req_i = 1'b0; host_req_i = 1'b0; host_lock_i = 1'b0;
    end else begin
      rst_i = (ph == 0) && ($urandom_range(0, 39) == 0);
      gen(ph);
    end
    eval();
  endtask

  // Scoreboard monitor: pops one prediction per cycle, away from the active edge
  always @(negedge clk_i) begin
    exp_t x;
    if (sb.size() > 0) begin
      x = sb.pop_front();
      chk("ctl{cg,hg,stall,we,re,crv,hrv}",
          {57'd0, core_gnt_o, host_gnt_o, core_stall_o, mem_we_o, mem_re_o,
           core_rvalid_o, host_rvalid_o}, {57'd0, x.ctl});
      chk("mem_addr", {56'd0, mem_addr_o}, {56'd0, x.addr});
      chk("mem_wdata", mem_wdata_o, x.wdata);
      chk("core_rdata", core_rdata_o, x.core_rd);
      chk("host_rdata", host_rdata_o, x.host_rd);
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = {$urandom, $urandom};
      bmem[i]    = ref_mem[i];
    end
    model_reset();
    e_cg = 0; e_hg = 0; e_crv = 0; e_hrv = 0;
    for (int c = 0; c < 3; c++) step(0, 1'b1);
    for (int c = 0; c < 1500; c++) step(0, 1'b0);
    for (int c = 0; c < 200; c++)  step(1, 1'b0);
    for (int c = 0; c < 300; c++)  step(2, 1'b0);
    for (int c = 0; c < 500; c++)  step(0, 1'b0);
    // Directed: reset, then both sides request continuously for 10 cycles
    step(0, 1'b1);
    for (int c = 0; c < 10; c++) step(1, 1'b0);
    @(posedge clk_i); #1;
    commit();
`ifdef DMEM_ARB_STATS_EN
    chk("stat_core_gnt", {32'd0, stat_core_gnt_o}, 64'd8);
    chk("stat_host_gnt", {32'd0, stat_host_gnt_o}, 64'd2);
    chk("stat_conflict", {32'd0, stat_conflict_o}, 64'd10);
    chk("stat_core_model", {32'd0, stat_core_gnt_o}, 64'(m_st_core));
`endif
    chk("model_core_gnts_10cyc", 64'(m_st_core), 64'd8);
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk_i);
    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
